// File: rtl/amber128_dmem_if.sv
// amber128 128-bit DMEM request/ready bundle.
// The initiator holds its request fields until it sees ready_o.
interface amber128_dmem_if;
    logic         req_i;
    logic         we_i;
    logic [63:0]  addr_i;
    logic [127:0] wdata_i;
    logic [127:0] rdata_o;
    logic         ready_o;
    logic         trap_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  rdata_o, ready_o, trap_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output rdata_o, ready_o, trap_o
    );
endinterface

// File: rtl/amber128_dmem_responder.sv
// amber128 DMEM responder: a 128-bit word store that answers each
// accepted request after a fixed latency with a one-cycle ready pulse.
module amber128_dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [63:0] BASE_ADDR   = 64'h0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clk_en_i,
    input  logic stall_i,
    amber128_dmem_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    // Accept-to-ready is LATENCY edges: LATENCY-1 of them are spent in WAIT.
    localparam logic [CW-1:0] CNT_INIT =
        CW'((LATENCY > 1) ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we_q, we_d;
    logic            fault_q, fault_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [127:0]    wdata_q, wdata_d;
    logic [127:0]    mem_q [DEPTH_WORDS];

    logic [63:0]     off;
    logic            fault_now;
    logic            resp;

    // Below-base is checked directly so an underflowed offset cannot alias.
    assign off       = bus.addr_i - BASE_ADDR;
    assign fault_now = (|bus.addr_i[3:0])
                     || (bus.addr_i < BASE_ADDR)
                     || ((off >> 4) >= 64'(DEPTH_WORDS));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        fault_d = fault_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_i) begin
                    we_d    = bus.we_i;
                    fault_d = fault_now;
                    idx_d   = off[AW+3:4];
                    wdata_d = bus.wdata_i;
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY > 1) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (!stall_i) begin
                    if (cnt_q == '0) state_d = RESP;
                    else             cnt_d   = cnt_q - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            fault_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else if (clk_en_i) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            fault_q <= fault_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
        end
    end

    assign resp = (state_q == RESP);

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (clk_en_i && resp && we_q && !fault_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign bus.ready_o = resp;
    assign bus.trap_o  = resp && fault_q;
    assign bus.rdata_o = (resp && !we_q && !fault_q) ? mem_q[idx_q] : '0;

endmodule

// File: tb/tb_amber128_dmem_responder.sv
// Directed bench for amber128_dmem_responder: two instances,
// one at base 0 (1024 words), one at base 0x1000 (16 words).
module tb_amber128_dmem_responder;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic clk_en_i;
    logic stall_i;

    always #5 clk_i = ~clk_i;

    amber128_dmem_if if0 ();
    amber128_dmem_if if1 ();

    amber128_dmem_responder #(
        .DEPTH_WORDS(1024),
        .LATENCY    (2),
        .BASE_ADDR  (64'h0)
    ) dut0 (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clk_en_i(clk_en_i),
        .stall_i (stall_i),
        .bus     (if0)
    );

    amber128_dmem_responder #(
        .DEPTH_WORDS(16),
        .LATENCY    (2),
        .BASE_ADDR  (64'h1000)
    ) dut1 (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clk_en_i(clk_en_i),
        .stall_i (stall_i),
        .bus     (if1)
    );

    int passed = 0;
    int total  = 0;

    logic [127:0] rd;
    logic         tr;
    logic         spur;
    int           lat;

    localparam logic [127:0] DA5 = {16{8'hA5}};
    localparam logic [127:0] D22 = {16{8'h22}};
    localparam logic [127:0] D11 = {16{8'h11}};
    localparam logic [127:0] D33 = {16{8'h33}};
    localparam logic [127:0] D44 = {16{8'h44}};
    localparam logic [127:0] D55 = {16{8'h55}};
    localparam logic [127:0] D66 = {16{8'h66}};
    localparam logic [127:0] D77 = {16{8'h77}};

    task automatic chk(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input int b, input logic r, input logic w,
                         input logic [63:0] a, input logic [127:0] d);
        if (b == 0) begin
            if0.req_i = r; if0.we_i = w;
            if0.addr_i = a; if0.wdata_i = d;
        end else begin
            if1.req_i = r; if1.we_i = w;
            if1.addr_i = a; if1.wdata_i = d;
        end
    endtask

    function automatic logic rdy(input int b);
        return (b == 0) ? if0.ready_o : if1.ready_o;
    endfunction

    task automatic start(input int b, input logic w,
                         input logic [63:0] a, input logic [127:0] d);
        @(negedge clk_i);
        drive(b, 1'b1, w, a, d);
    endtask

    // Cycle count is edges after the accept cycle; -1 means timeout.
    task automatic wait_rdy(input int b, input int from, output int l,
                            output logic [127:0] r, output logic t);
        l = -1; r = '0; t = 1'b0;
        for (int i = from + 1; i <= from + 20; i++) begin
            @(posedge clk_i); #1;
            if (rdy(b)) begin
                l = i;
                r = (b == 0) ? if0.rdata_o : if1.rdata_o;
                t = (b == 0) ? if0.trap_o : if1.trap_o;
                break;
            end
        end
    endtask

    task automatic finish_txn(input int b, input string tag);
        @(negedge clk_i);
        drive(b, 1'b0, 1'b0, 64'h0, '0);
        @(posedge clk_i); #1;
        chk({tag, "_pulse"}, 128'(rdy(b)), 128'(0));
    endtask

    task automatic txn(input int b, input logic w, input logic [63:0] a,
                       input logic [127:0] d, input string tag,
                       input logic [127:0] erd, input logic etr);
        start(b, w, a, d);
        wait_rdy(b, 0, lat, rd, tr);
        chk({tag, "_lat"}, 128'(lat), 128'(2));
        chk({tag, "_rdata"}, rd, erd);
        chk({tag, "_trap"}, 128'(tr), 128'(etr));
        finish_txn(b, tag);
    endtask

    initial begin
        rst_ni   = 1'b0;
        clk_en_i = 1'b1;
        stall_i  = 1'b0;
        drive(0, 1'b0, 1'b0, 64'h0, '0);
        drive(1, 1'b0, 1'b0, 64'h0, '0);
        #12;
        chk("rst_ready", 128'(if0.ready_o), 128'(0));
        chk("rst_trap", 128'(if0.trap_o), 128'(0));
        chk("rst_rdata", if0.rdata_o, '0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        txn(0, 1'b1, 64'h20, DA5, "st20", '0, 1'b0);
        txn(0, 1'b0, 64'h20, '0, "ld20", DA5, 1'b0);
        txn(0, 1'b0, 64'h28, '0, "mis28", '0, 1'b1);
        txn(0, 1'b0, 64'h20, '0, "reld20", DA5, 1'b0);

        txn(0, 1'b1, 64'h0, D22, "st0", '0, 1'b0);
        txn(0, 1'b1, 64'h4000, D11, "oor", '0, 1'b1);
        txn(0, 1'b0, 64'h0, '0, "ld0", D22, 1'b0);

        txn(1, 1'b1, 64'h10F0, D33, "b_stlast", '0, 1'b0);
        txn(1, 1'b0, 64'h0FF0, '0, "b_ldbelow", '0, 1'b1);
        txn(1, 1'b1, 64'h0FF0, D44, "b_stbelow", '0, 1'b1);
        txn(1, 1'b0, 64'h10F0, '0, "b_ldlast", D33, 1'b0);

        // Three stalled WAIT cycles.
        start(0, 1'b0, 64'h20, '0);
        stall_i = 1'b1;
        spur = 1'b0;
        repeat (4) begin
            @(posedge clk_i); #1;
            spur |= if0.ready_o;
        end
        @(negedge clk_i);
        stall_i = 1'b0;
        chk("stall_spur", 128'(spur), 128'(0));
        wait_rdy(0, 4, lat, rd, tr);
        chk("stall_lat", 128'(lat), 128'(5));
        chk("stall_rdata", rd, DA5);
        finish_txn(0, "stall");

        // Two frozen cycles while in WAIT.
        start(0, 1'b0, 64'h20, '0);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        clk_en_i = 1'b0;
        spur = 1'b0;
        repeat (2) begin
            @(posedge clk_i); #1;
            spur |= if0.ready_o;
        end
        @(negedge clk_i);
        clk_en_i = 1'b1;
        chk("cken_spur", 128'(spur), 128'(0));
        wait_rdy(0, 3, lat, rd, tr);
        chk("cken_lat", 128'(lat), 128'(4));
        chk("cken_rdata", rd, DA5);
        finish_txn(0, "cken");

        // Reset during WAIT must drop the store.
        txn(0, 1'b1, 64'h40, D55, "st40", '0, 1'b0);
        start(0, 1'b1, 64'h40, D66);
        @(posedge clk_i); #2;
        rst_ni = 1'b0;
        drive(0, 1'b0, 1'b0, 64'h0, '0);
        #1;
        chk("rstw_ready", 128'(if0.ready_o), 128'(0));
        chk("rstw_trap", 128'(if0.trap_o), 128'(0));
        @(posedge clk_i); #1;
        chk("rstw_hold", 128'(if0.ready_o), 128'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        txn(0, 1'b0, 64'h40, '0, "ld40", D55, 1'b0);

        // Back-to-back: req stays high across RESP.
        start(0, 1'b1, 64'h60, D77);
        wait_rdy(0, 0, lat, rd, tr);
        chk("b2b1_lat", 128'(lat), 128'(2));
        chk("b2b1_trap", 128'(tr), 128'(0));
        @(negedge clk_i);
        drive(0, 1'b1, 1'b0, 64'h60, '0);
        @(posedge clk_i); #1;
        chk("b2b_gap", 128'(if0.ready_o), 128'(0));
        wait_rdy(0, 3, lat, rd, tr);
        chk("b2b2_lat", 128'(lat), 128'(5));
        chk("b2b2_rdata", rd, D77);
        finish_txn(0, "b2b2");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
